ahb_decode_mux_err: RTL
=======================

# ahb_decode_mux_err

Parametrised AHB-Lite address decoder and response multiplexer connecting the Cortex-M0 system bus to NUM_PORTS slaves. It replaces the fixed four-port interconnect with a table-driven address map. A built-in default slave returns a two-cycle ERROR response for unmapped transfers. An error logger captures the faulting address, keeps a saturating error count and raises a sticky interrupt suitable for an IRQ line.

## Interface

Reset is `RSTn`: asynchronous, active-low. Clock is `clk`.

**Parameters**
- `NUM_PORTS`, default 4: number of slave ports, legal range 1..8.
- `DATA_WIDTH`, default 32: width of the HRDATA path.
- `PORT_REGION`, default {4'h5,4'h4,4'h2,4'h0}: packed NUM_PORTS×4 bits. Entry i (bits i*4+:4) is matched against HADDR[31:28].
- `COUNT_WIDTH`, default 8: width of the error counter.

**Ports**
- `clk` in 1: bus clock.
- `RSTn` in 1: asynchronous active-low reset.
- `HADDR` in 32: master address.
- `HTRANS` in 2: master transfer type.
- `HREADY` out 1: muxed ready, driven to the master.
- `HRESP` out 1: muxed response, driven to the master.
- `HRDATA` out DATA_WIDTH: muxed read data, driven to the master.
- `HSEL_S` out NUM_PORTS: per-slave select.
- `HREADY_S` out 1: copy of HREADY, broadcast to all slaves.
- `HREADYOUT_S` in NUM_PORTS: per-slave ready.
- `HRESP_S` in NUM_PORTS: per-slave response.
- `HRDATA_S` in NUM_PORTS×DATA_WIDTH: slave i read data at bits i*DATA_WIDTH+:DATA_WIDTH.
- `err_clr` in 1: single-cycle clear of err_irq and err_count.
- `err_irq` out 1: sticky decode-error flag.
- `err_addr` out 32: HADDR of the most recent unmapped transfer.
- `err_count` out COUNT_WIDTH: saturating count of unmapped transfers.

Other master signals (HWRITE, HSIZE, HWDATA, …) are routed straight to the slaves outside this block.

## Operation

**Address decode (combinational)**
- hit[i] = (PORT_REGION[i*4+:4] == HADDR[31:28]).
- If several entries match, the lowest index wins.
- HSEL_S = the one-hot priority result. It does not depend on HTRANS.
- unmapped = no hit.

**Data-phase select register `dsel`**
- dsel is one of {NONE, PORT[i], DEF}.
- It updates only when HREADY=1:
  - on a hit → PORT[i];
  - unmapped with HTRANS[1]=1 (NONSEQ/SEQ) → DEF;
  - otherwise → NONE.
- Reset value: NONE.

**Response mux**
- dsel=PORT[i]: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=slave i data. Slave ERROR responses pass through unaltered and are not logged.
- dsel=NONE: HREADY=1, HRESP=0, HRDATA=0.
- dsel=DEF: outputs are driven by the default-slave FSM.

**Default-slave FSM**
- States: IDLE, ERR1, ERR2.
- IDLE → ERR1 when an unmapped NONSEQ/SEQ is accepted (HREADY=1).
- ERR1 drives HREADY=0, HRESP=1; next state is always ERR2.
- ERR2 drives HREADY=1, HRESP=1.
  - A new unmapped NONSEQ/SEQ accepted in this cycle → ERR1.
  - Otherwise → IDLE.
- HRDATA=0 throughout.

**Error logger** (updates on the IDLE→ERR1 or ERR2→ERR1 transition)
- err_addr ← HADDR.
- err_count increments and saturates at 2^COUNT_WIDTH−1.
- err_irq ← 1.
- err_clr sets err_irq=0 and err_count=0.
- Simultaneous new error and err_clr: err_irq=1, err_count=1, err_addr updated.

## Timing

- Reset values: err_irq=0, err_addr=0, err_count=0, FSM=IDLE, dsel=NONE. This gives HREADY=1, HRESP=0, HRDATA=0 after reset; HSEL_S follows HADDR combinationally.
- HSEL_S has zero latency from HADDR.
- The mux takes effect one cycle after address-phase acceptance, matching the AHB data phase.
- Mapped transfer: latency equals the slave's wait states, with no added cycles.
- Unmapped transfer: always exactly 2 data-phase cycles.
- Back-to-back unmapped transfers: ERR1, ERR2, ERR1, ERR2, …
- Back-to-back mapped transfers to different ports switch dsel at each HREADY=1 edge with no bubble.
- err_* outputs are registered and change one cycle after the triggering acceptance.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous). No partial ERROR is completed.

## Test plan

1. Reset, then NONSEQ read to 0x2000_0010 with slave1 returning 0xCAFEF00D and zero wait states → HSEL_S=4'b0010, next cycle HRDATA=0xCAFEF00D, HREADY=1, HRESP=0.
2. Slave3 (0x5000_0000) holds HREADYOUT low for 3 cycles → master HREADY low for exactly 3 cycles; no err_* change.
3. NONSEQ to 0x9000_0004 → HSEL_S=0, then HREADY/HRESP = 0/1 then 1/1, err_addr=0x9000_0004, err_count=1, err_irq=1. The same address with HTRANS=IDLE → zero-wait OKAY and no log.
4. Back-to-back unmapped transfers to 0x9000_0000 and 0xA000_0000 → ERR1, ERR2, ERR1, ERR2; err_count=2; err_addr=0xA000_0000.
5. COUNT_WIDTH=2 build, 5 unmapped transfers → err_count saturates at 3. err_clr pulsed in the same cycle as a new error → err_count=1, err_irq=1.
6. NUM_PORTS=6 build with PORT_REGION entries 2 and 4 both equal to 4'h6; access 0x6000_0000 → HSEL_S=6'b000100 only.

Source files
------------

// File: rtl/ahb_decode_mux_err.sv
// ---------------------------------------------------------------------------
// ahb_decode_mux_err
//
// AHB-Lite address decoder and response multiplexer for NUM_PORTS slaves,
// with a built-in default slave and a decode-error logger.
//
// Address decode is table driven. Entry i of PORT_REGION is compared with
// HADDR[31:28]. When several entries match, the lowest index wins. A
// NONSEQ/SEQ transfer that matches no entry goes to the default slave. The
// default slave answers with the standard two-cycle ERROR response. The
// logger then records the faulting address, bumps a saturating counter and
// sets a sticky interrupt flag.
//
// Ports
//   clk, RSTn      bus clock, asynchronous active-low reset
//   HADDR, HTRANS  master address-phase signals
//   HREADY, HRESP  muxed data-phase response to the master
//   HRDATA         muxed read data to the master
//   HSEL_S         one-hot slave select (combinational from HADDR)
//   HREADY_S       copy of HREADY broadcast to every slave
//   HREADYOUT_S    per-slave ready
//   HRESP_S        per-slave response
//   HRDATA_S       per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   err_clr        one-cycle clear of err_irq and err_count
//   err_irq        sticky decode-error flag
//   err_addr       HADDR of the most recent unmapped transfer
//   err_count      saturating count of unmapped transfers
// ---------------------------------------------------------------------------
module ahb_decode_mux_err #(
  parameter int                     NUM_PORTS   = 4,
  parameter int                     DATA_WIDTH  = 32,
  parameter logic [NUM_PORTS*4-1:0] PORT_REGION = {4'h5, 4'h4, 4'h2, 4'h0},
  parameter int                     COUNT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            RSTn,
  input  logic [31:0]                     HADDR,
  input  logic [1:0]                      HTRANS,
  output logic                            HREADY,
  output logic                            HRESP,
  output logic [DATA_WIDTH-1:0]           HRDATA,
  output logic [NUM_PORTS-1:0]            HSEL_S,
  output logic                            HREADY_S,
  input  logic [NUM_PORTS-1:0]            HREADYOUT_S,
  input  logic [NUM_PORTS-1:0]            HRESP_S,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] HRDATA_S,
  input  logic                            err_clr,
  output logic                            err_irq,
  output logic [31:0]                     err_addr,
  output logic [COUNT_WIDTH-1:0]          err_count
);

  typedef enum logic [1:0] {
    DEF_IDLE = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_t;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == {COUNT_WIDTH{1'b1}}) return v;
    return v + COUNT_WIDTH'(1);
  endfunction

  logic [NUM_PORTS-1:0] hsel_p0;
  logic                 hit_p0;
  logic                 xfer_req_p0;
  logic                 err_evt_p0;

  logic [NUM_PORTS-1:0] dsel_port_p1;
  logic                 dsel_def_p1;
  def_state_t           def_state_p1;
  logic                 def_hready_p1;
  logic                 def_hresp_p1;

  logic                  hready_mux;
  logic                  hresp_mux;
  logic [DATA_WIDTH-1:0] hrdata_mux;

  // ---- address phase: priority decode, lowest matching entry wins ----
  always_comb begin
    hsel_p0 = '0;
    hit_p0  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!hit_p0 && (PORT_REGION[i*4 +: 4] == HADDR[31:28])) begin
        hsel_p0[i] = 1'b1;
        hit_p0     = 1'b1;
      end
    end
  end

  // NONSEQ (2'b10) or SEQ (2'b11); IDLE and BUSY never reach a slave.
  assign xfer_req_p0 = (HTRANS == 2'b10) || (HTRANS == 2'b11);

  // An unmapped real transfer accepted this cycle. HREADY is low during
  // ERR1, so this fires only from IDLE or ERR2 of the default slave.
  assign err_evt_p0  = hready_mux && !hit_p0 && xfer_req_p0;

  assign HSEL_S = hsel_p0;

  // ---- data phase: select register, advances only when HREADY is high ----
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      dsel_port_p1 <= '0;
      dsel_def_p1  <= 1'b0;
    end else if (hready_mux) begin
      // All-zero dsel_port_p1 with dsel_def_p1 low means "no slave".
      dsel_port_p1 <= hsel_p0;
      dsel_def_p1  <= !hit_p0 && xfer_req_p0;
    end
  end

  // Default-slave FSM with registered HREADY/HRESP.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      def_state_p1  <= DEF_IDLE;
      def_hready_p1 <= 1'b1;
      def_hresp_p1  <= 1'b0;
    end else begin
      unique case (def_state_p1)
        DEF_IDLE, DEF_ERR2: begin
          if (err_evt_p0) begin
            def_state_p1  <= DEF_ERR1;
            def_hready_p1 <= 1'b0;
            def_hresp_p1  <= 1'b1;
          end else begin
            def_state_p1  <= DEF_IDLE;
            def_hready_p1 <= 1'b1;
            def_hresp_p1  <= 1'b0;
          end
        end
        DEF_ERR1: begin
          def_state_p1  <= DEF_ERR2;
          def_hready_p1 <= 1'b1;
          def_hresp_p1  <= 1'b1;
        end
        default: begin
          def_state_p1  <= DEF_IDLE;
          def_hready_p1 <= 1'b1;
          def_hresp_p1  <= 1'b0;
        end
      endcase
    end
  end

  // Error logger. A new error wins over a simultaneous clear, so the
  // counter restarts at one and the flag stays set.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      err_irq   <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      if (err_evt_p0) begin
        err_addr <= HADDR;
      end
      if (err_evt_p0) begin
        err_irq <= 1'b1;
      end else if (err_clr) begin
        err_irq <= 1'b0;
      end
      if (err_clr) begin
        err_count <= err_evt_p0 ? COUNT_WIDTH'(1) : '0;
      end else if (err_evt_p0) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

  // ---- data phase: response mux ----
  always_comb begin
    hready_mux = 1'b1;
    hresp_mux  = 1'b0;
    hrdata_mux = '0;
    if (dsel_def_p1) begin
      hready_mux = def_hready_p1;
      hresp_mux  = def_hresp_p1;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (dsel_port_p1[i]) begin
          hready_mux = HREADYOUT_S[i];
          hresp_mux  = HRESP_S[i];
          hrdata_mux = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign HREADY   = hready_mux;
  assign HRESP    = hresp_mux;
  assign HRDATA   = hrdata_mux;
  assign HREADY_S = hready_mux;

endmodule
